// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph type, blank constant and hex glyph lookup.
package seg_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}
  function automatic seg_t hex_glyph(input logic [NIBBLE_W-1:0] nib);
    seg_t g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Bundle between the value producer (master) and the display scanner (slave).
interface seg_display_scanner_if
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic [NIBBLE_W*NUM_DIGITS-1:0] value;
  logic                           load;
  logic [NUM_DIGITS-1:0]          dp_mask;
  seg_t                           seg;
  logic                           dp;
  logic [NUM_DIGITS-1:0]          an;
  logic                           frame;

  modport master (output value, load, dp_mask, input seg, dp, an, frame);
  modport slave  (input value, load, dp_mask, output seg, dp, an, frame);

endinterface

// File: rtl/seg_display_scanner_decoder.sv
// Shared hex-to-seven-segment decoder (active-low cathodes).
module seg_display_scanner_decoder
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output seg_t                seg
);

  assign seg = hex_glyph(nibble);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed scanner for a common-anode multi-digit seven-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  seg_display_scanner_if.slave bus
);

  localparam int unsigned VALUE_W = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRESC_W-1:0]    presc;
  logic [IDX_W-1:0]      idx;
  logic [VALUE_W-1:0]    shadow;
  logic [VALUE_W-1:0]    disp;
  logic [NUM_DIGITS-1:0] an_q;
  seg_t                  seg_q;
  logic                  dp_q;
  logic                  frame_q;

  logic                presc_tc_c;
  logic                frame_start_c;
  logic                dead_c;
  logic                blank_c;
  logic [NIBBLE_W-1:0] nibble_c;
  seg_t                glyph_c;

  // Slot timing and current digit selection
  always_comb begin
    presc_tc_c    = (presc == PRESC_W'(REFRESH_DIV - 1));
    frame_start_c = (presc == '0) && (idx == '0);
    dead_c        = (presc < PRESC_W'(DEAD_CYCLES));
    nibble_c      = disp[NIBBLE_W*int'(idx) +: NIBBLE_W];
`ifdef LEADING_ZERO_BLANK_EN
    blank_c       = (idx != '0) && ((disp >> (NIBBLE_W*int'(idx))) == '0);
`else
    blank_c       = 1'b0;
`endif
  end

  seg_display_scanner_decoder u_decoder (
    .nibble (nibble_c),
    .seg    (glyph_c)
  );

  // The display copy happens while the index sits at the frame start, so a whole
  // frame always shows one snapshot; a LOAD in that same cycle lands next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      idx     <= '0;
      shadow  <= '0;
      disp    <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      presc <= presc_tc_c ? '0 : presc + PRESC_W'(1);
      if (presc_tc_c)
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      if (bus.load)
        shadow <= bus.value;
      if (frame_start_c)
        disp <= shadow;
      frame_q <= frame_start_c;
      if (dead_c) begin
        an_q  <= '1;
        seg_q <= SEG_BLANK;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(NUM_DIGITS'(1) << idx);
        seg_q <= blank_c ? SEG_BLANK : glyph_c;
        dp_q  <= ~bus.dp_mask[idx];
      end
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: directed scenarios plus random loads against a frame-level model.
module tb_seg_display_scanner;
  import seg_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned R  = 4;
  localparam int unsigned D  = 1;
  localparam int unsigned NR = N * R;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_display_scanner_if #(.NUM_DIGITS(N)) bus ();

  seg_display_scanner #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .DEAD_CYCLES (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Model: cycles since reset, value loaded so far, value frozen for the current frame
  int unsigned sc       = 0;
  logic [15:0] shadow_m = '0;
  logic [15:0] frame_m  = '0;
  seg_t        lit_seg [N];
  logic [N-1:0] lit_dp  = '1;

  function automatic seg_t glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive inputs, predict, clock, compare
  task automatic tick(input logic r, input logic ld, input logic [15:0] v, input logic [N-1:0] m);
    int unsigned slot, d;
    logic [N-1:0] an_e;
    seg_t seg_e;
    logic dp_e, fr_e;
    rst = r; bus.load = ld; bus.value = v; bus.dp_mask = m;
    slot = sc % R;
    d    = (sc / R) % N;
    an_e = '1; seg_e = 7'h7F; dp_e = 1'b1; fr_e = 1'b0;
    if (!r) begin
      if (sc % NR == 0) frame_m = shadow_m;
      fr_e = (sc % NR == 0);
      if (slot >= D) begin
        an_e[d] = 1'b0;
        seg_e   = glyph(frame_m[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0 && (frame_m >> (4*d)) == 16'h0) seg_e = 7'h7F;
`endif
        dp_e = ~m[d];
      end
      if (ld) shadow_m = v;
    end
    @(posedge clk);
    #1;
    chk("an",        16'(bus.an),    16'(an_e));
    chk("seg",       16'(bus.seg),   16'(seg_e));
    chk("dp",        16'(bus.dp),    16'(dp_e));
    chk("frame",     16'(bus.frame), 16'(fr_e));
    chk("an_onehot", 16'($countones(~bus.an) <= 1), 16'h1);
    for (int i = 0; i < int'(N); i++)
      if (bus.an[i] == 1'b0) begin
        lit_seg[i] = bus.seg;
        lit_dp[i]  = bus.dp;
      end
    if (r) begin
      sc = 0; shadow_m = '0; frame_m = '0;
    end else begin
      sc++;
    end
  endtask

  task automatic idle(input int unsigned n, input logic [N-1:0] m);
    for (int unsigned i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, m);
  endtask

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.dp_mask = '0;
    for (int i = 0; i < int'(N); i++) lit_seg[i] = 7'h7F;

    // Reset held for three cycles
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    chk("rst_an", 16'(bus.an), 16'hF);
    chk("rst_seg", 16'(bus.seg), 16'h7F);

    // First slot after release: one dead cycle then digit 0
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    chk("rel_c1_an", 16'(bus.an), 16'hF);
    tick(1'b0, 1'b0, 16'h0, 4'h0);
    chk("rel_c2_an", 16'(bus.an), 16'hE);
    idle(NR - 2, 4'h0);

    // Load 12AF mid-frame; it appears from the next frame start
    idle(1, 4'h0);
    tick(1'b0, 1'b1, 16'h12AF, 4'h0);
    idle(2*NR - (sc % NR) - NR, 4'h0);
    idle(NR, 4'h0);
    chk("scan_d0_F", 16'(lit_seg[0]), 16'h0E);
    chk("scan_d1_A", 16'(lit_seg[1]), 16'h08);
    chk("scan_d2_2", 16'(lit_seg[2]), 16'h24);
    chk("scan_d3_1", 16'(lit_seg[3]), 16'h79);

    // Tearing guard: load 0000 while digit 2 is lit
    idle(2*R + 1, 4'h0);
    tick(1'b0, 1'b1, 16'h0000, 4'h0);
    idle(NR - (sc % NR), 4'h0);
    chk("tear_d2_old", 16'(lit_seg[2]), 16'h24);
    chk("tear_d3_old", 16'(lit_seg[3]), 16'h79);
    idle(NR, 4'h0);
    chk("tear_d0_new", 16'(lit_seg[0]), 16'h40);

    // LOAD on the frame-start cycle shows one frame later
    tick(1'b0, 1'b1, 16'h5555, 4'h0);
    idle(NR - 1, 4'h0);
    chk("sim_d0_old", 16'(lit_seg[0]), 16'h40);
    idle(NR, 4'h0);
    chk("sim_d0_new", 16'(lit_seg[0]), 16'h12);
    chk("sim_d3_new", 16'(lit_seg[3]), 16'h12);

    // Decimal point on digit 2 only, leading-zero handling on digit 3
    idle(1, 4'b0100);
    tick(1'b0, 1'b1, 16'h0030, 4'b0100);
    idle(NR - (sc % NR), 4'b0100);
    idle(NR, 4'b0100);
    chk("dp_only_d2", 16'(lit_dp), 16'(4'b1011));
    chk("dp_d1_3", 16'(lit_seg[1]), 16'h30);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb_d3", 16'(lit_seg[3]), 16'h7F);
`else
    chk("lzb_d3", 16'(lit_seg[3]), 16'h40);
`endif

    // Random loads and live decimal-point masks
    for (int unsigned i = 0; i < 300; i++)
      tick(1'b0, ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));

    // Mid-scan reset during digit 2
    for (int unsigned i = 0; i < NR && ((sc % NR) / R) != 2; i++) idle(1, 4'h0);
    chk("reached_d2", 16'((sc % NR) / R), 16'h2);
    tick(1'b1, 1'b0, 16'h0, 4'h0);
    chk("mid_rst_an", 16'(bus.an), 16'hF);
    chk("mid_rst_seg", 16'(bus.seg), 16'h7F);
    idle(NR, 4'h0);
    chk("restart_d0_0", 16'(lit_seg[0]), 16'h40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
